// File: rtl/edge_event_fifo_if.sv
// Event stream from edge_event_fifo to its consumer.
// It carries the valid/ready handshake and the head event fields.
interface edge_event_fifo_if #(
  parameter int CH_W = 2,
  parameter int TS_W = 8
) ();
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_src;
  logic [TS_W-1:0] evt_ts;

  modport master (output evt_valid, evt_ch, evt_src, evt_ts, input evt_ready);
  modport slave  (input evt_valid, evt_ch, evt_src, evt_ts, output evt_ready);
endinterface

// File: rtl/edge_event_fifo.sv
// Multi-channel rising-edge detector with per-slot timestamps.
// A round-robin arbiter feeds the events into a FIFO that drains over valid/ready.
module edge_event_fifo #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      a,
  input  logic [NUM_CH-1:0]      b,
  input  logic                   clr,
  edge_event_fifo_if.master      evt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int NSLOT  = 2 * NUM_CH;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SLOT_W = $clog2(NSLOT);
  localparam int AW     = $clog2(DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int ENT_W  = CH_W + 1 + TS_W;

  logic [TS_W-1:0]   ts;
  logic [NSLOT-1:0]  in_vec, in_q, rise, pending, gnt_vec, drop;
  logic [TS_W-1:0]   ts_slot [NSLOT];
  logic [SLOT_W-1:0] rr_ptr, grant_idx, cand;
  logic              grant, pop;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  head;
  logic [AW-1:0]     wr_ptr, rd_ptr;

  // Slot j = 2*ch + src interleaves a and b of each channel.
  always_comb begin
    in_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_vec[2*c]   = a[c];
      in_vec[2*c+1] = b[c];
    end
  end

  assign rise = in_vec & ~in_q;

  // Descending scan so the lowest offset from rr_ptr wins without an early exit.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    gnt_vec   = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      cand = SLOT_W'((int'(rr_ptr) + i) % NSLOT);
      if (pending[cand] && !clr && (level != LVL_W'(DEPTH))) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant) gnt_vec[grant_idx] = 1'b1;
  end

  assign drop = rise & pending & ~gnt_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts       <= '0;
      in_q     <= '0;
      pending  <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
      for (int j = 0; j < NSLOT; j++) ts_slot[j] <= '0;
    end else begin
      ts   <= ts + TS_W'(1);
      in_q <= in_vec;
      if (clr) begin
        pending  <= '0;
        rr_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        pending <= (pending & ~gnt_vec) | rise;
        if (|drop) overflow <= 1'b1;
        if (grant) rr_ptr <= (grant_idx == SLOT_W'(NSLOT - 1)) ? '0 : grant_idx + SLOT_W'(1);
        for (int j = 0; j < NSLOT; j++)
          if (rise[j] && !drop[j]) ts_slot[j] <= ts;
      end
    end
  end

  assign pop = evt.evt_valid & evt.evt_ready;

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (grant) mem[wr_ptr] <= {CH_W'(grant_idx >> 1), grant_idx[0], ts_slot[grant_idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (grant && !pop)      level <= level + LVL_W'(1);
      else if (!grant && pop) level <= level - LVL_W'(1);
    end
  end

  assign evt.evt_valid = (level != '0);

  always_comb begin
    head = '0;
    if (evt.evt_valid) head = mem[rd_ptr];
  end

  assign evt.evt_ch  = head[ENT_W-1 -: CH_W];
  assign evt.evt_src = head[TS_W];
  assign evt.evt_ts  = head[TS_W-1:0];
endmodule

// File: tb/tb_edge_event_fifo.sv
// Directed bench for edge_event_fifo (NUM_CH=4, DEPTH=8, TS_W=4).
// Stimulus is placed on cycles counted from reset release, where ts equals the cycle number mod 16.
module tb_edge_event_fifo;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a     = '0;
  logic [3:0] b     = '0;
  logic       clr   = 1'b0;
  logic [3:0] level;
  logic       overflow;
  int         cyc;
  int         tests_run    = 0;
  int         tests_failed = 0;

  edge_event_fifo_if #(.CH_W(2), .TS_W(4)) evt_bus ();

  edge_event_fifo #(.NUM_CH(4), .DEPTH(8), .TS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .evt(evt_bus), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; inputs are driven and outputs sampled on the negedge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic goto(input int n);
    int guard = 0;
    while (cyc < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL goto: at cycle %0d, wanted %0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; a = '0; b = '0; clr = 1'b0; evt_bus.evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    tests_run++; if (evt_bus.evt_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b want 0", evt_bus.evt_valid); end
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    tests_run++; if (evt_bus.evt_ch !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_ch: got %0d want 0", evt_bus.evt_ch); end
    tests_run++; if (evt_bus.evt_src !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_src: got %b want 0", evt_bus.evt_src); end
    tests_run++; if (evt_bus.evt_ts !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_ts: got %0d want 0", evt_bus.evt_ts); end
  endtask

  task automatic test_single();
    do_reset();
    goto(5); a[2] = 1'b1;
    goto(6); a[2] = 1'b0;
    tests_run++; if (evt_bus.evt_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_early: got %b want 0", evt_bus.evt_valid); end
    goto(7);
    tests_run++; if (evt_bus.evt_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_valid: got %b want 1", evt_bus.evt_valid); end
    tests_run++; if (evt_bus.evt_ch !== 2'd2) begin tests_failed++; $display("[TB] FAIL single_ch: got %0d want 2", evt_bus.evt_ch); end
    tests_run++; if (evt_bus.evt_src !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_src: got %b want 0", evt_bus.evt_src); end
    tests_run++; if (evt_bus.evt_ts !== 4'd5) begin tests_failed++; $display("[TB] FAIL single_ts: got %0d want 5", evt_bus.evt_ts); end
    tests_run++; if (level !== 4'd1) begin tests_failed++; $display("[TB] FAIL single_level: got %0d want 1", level); end
    evt_bus.evt_ready = 1'b1;
    goto(8);
    evt_bus.evt_ready = 1'b0;
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("[TB] FAIL single_pop_level: got %0d want 0", level); end
    tests_run++; if (evt_bus.evt_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_pop_valid: got %b want 0", evt_bus.evt_valid); end
  endtask

  task automatic test_round_robin();
    int exp_slot [3] = '{0, 1, 6};
    do_reset();
    goto(10); a = 4'b1001; b = 4'b0001;
    goto(11); a = '0; b = '0;
    goto(14);
    tests_run++; if (level !== 4'd3) begin tests_failed++; $display("[TB] FAIL rr_level: got %0d want 3", level); end
    for (int i = 0; i < 3; i++) begin
      goto(14 + i);
      tests_run++; if (evt_bus.evt_ch !== 2'(exp_slot[i] >> 1)) begin tests_failed++; $display("[TB] FAIL rr_ch[%0d]: got %0d want %0d", i, evt_bus.evt_ch, exp_slot[i] >> 1); end
      tests_run++; if (evt_bus.evt_src !== 1'(exp_slot[i] & 1)) begin tests_failed++; $display("[TB] FAIL rr_src[%0d]: got %b want %0d", i, evt_bus.evt_src, exp_slot[i] & 1); end
      tests_run++; if (evt_bus.evt_ts !== 4'd10) begin tests_failed++; $display("[TB] FAIL rr_ts[%0d]: got %0d want 10", i, evt_bus.evt_ts); end
      evt_bus.evt_ready = 1'b1;
    end
    goto(17);
    evt_bus.evt_ready = 1'b0;
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("[TB] FAIL rr_drained: got %0d want 0", level); end
    // rr_ptr should now be 7, so slot 7 beats slot 0.
    a[0] = 1'b1; b[3] = 1'b1;
    goto(18); a = '0; b = '0;
    goto(19);
    tests_run++; if (evt_bus.evt_ch !== 2'd3) begin tests_failed++; $display("[TB] FAIL rr_ptr_ch: got %0d want 3", evt_bus.evt_ch); end
    tests_run++; if (evt_bus.evt_src !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_ptr_src: got %b want 1", evt_bus.evt_src); end
    tests_run++; if (evt_bus.evt_ts !== 4'd1) begin tests_failed++; $display("[TB] FAIL rr_ptr_ts: got %0d want 1", evt_bus.evt_ts); end
    goto(20);
    tests_run++; if (level !== 4'd2) begin tests_failed++; $display("[TB] FAIL rr_ptr_level: got %0d want 2", level); end
    tests_run++; if (evt_bus.evt_ch !== 2'd3) begin tests_failed++; $display("[TB] FAIL rr_head_stable: got %0d want 3", evt_bus.evt_ch); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    goto(3); a = 4'hF; b = 4'hF;
    goto(4); a = '0; b = '0;
    goto(12);
    tests_run++; if (level !== 4'd8) begin tests_failed++; $display("[TB] FAIL full_level: got %0d want 8", level); end
    a[0] = 1'b1;
    goto(13); a[0] = 1'b0;
    tests_run++; if (level !== 4'd8) begin tests_failed++; $display("[TB] FAIL full_hold: got %0d want 8", level); end
    goto(14);
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_no_ovf: got %b want 0", overflow); end
    a[0] = 1'b1;
    goto(15); a[0] = 1'b0;
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_ovf: got %b want 1", overflow); end
    tests_run++; if (level !== 4'd8) begin tests_failed++; $display("[TB] FAIL full_ovf_level: got %0d want 8", level); end
    goto(16); evt_bus.evt_ready = 1'b1;
    goto(17); evt_bus.evt_ready = 1'b0;
    tests_run++; if (level !== 4'd7) begin tests_failed++; $display("[TB] FAIL full_pop_no_push: got %0d want 7", level); end
    tests_run++; if (evt_bus.evt_src !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_head_src: got %b want 1", evt_bus.evt_src); end
    tests_run++; if (evt_bus.evt_ts !== 4'd3) begin tests_failed++; $display("[TB] FAIL full_head_ts: got %0d want 3", evt_bus.evt_ts); end
    goto(18);
    tests_run++; if (level !== 4'd8) begin tests_failed++; $display("[TB] FAIL full_refill: got %0d want 8", level); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_ovf_sticky: got %b want 1", overflow); end
    clr = 1'b1; a[1] = 1'b1;
    goto(19); clr = 1'b0;
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("[TB] FAIL clr_level: got %0d want 0", level); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_ovf: got %b want 0", overflow); end
    tests_run++; if (evt_bus.evt_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_valid: got %b want 0", evt_bus.evt_valid); end
    goto(21);
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("[TB] FAIL clr_edge_discard: got %0d want 0", level); end
  endtask

  task automatic test_same_cycle_regrant();
    int exp_slot [4] = '{0, 1, 4, 4};
    int exp_ts   [4] = '{2, 2, 2, 5};
    do_reset();
    goto(2); a = 4'b0101; b = 4'b0001;
    goto(3); a = '0; b = '0;
    goto(5); a[2] = 1'b1;
    goto(6); a[2] = 1'b0;
    goto(7);
    tests_run++; if (level !== 4'd4) begin tests_failed++; $display("[TB] FAIL regrant_level: got %0d want 4", level); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL regrant_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      goto(7 + i);
      tests_run++; if (evt_bus.evt_ch !== 2'(exp_slot[i] >> 1)) begin tests_failed++; $display("[TB] FAIL regrant_ch[%0d]: got %0d want %0d", i, evt_bus.evt_ch, exp_slot[i] >> 1); end
      tests_run++; if (evt_bus.evt_src !== 1'(exp_slot[i] & 1)) begin tests_failed++; $display("[TB] FAIL regrant_src[%0d]: got %b want %0d", i, evt_bus.evt_src, exp_slot[i] & 1); end
      tests_run++; if (evt_bus.evt_ts !== 4'(exp_ts[i])) begin tests_failed++; $display("[TB] FAIL regrant_ts[%0d]: got %0d want %0d", i, evt_bus.evt_ts, exp_ts[i]); end
      evt_bus.evt_ready = 1'b1;
    end
    goto(11);
    evt_bus.evt_ready = 1'b0;
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("[TB] FAIL regrant_drained: got %0d want 0", level); end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    goto(15); b[1] = 1'b1;
    goto(16); b[1] = 1'b0;
    goto(17); b[1] = 1'b1;
    goto(18); b[1] = 1'b0;
    goto(19);
    tests_run++; if (level !== 4'd2) begin tests_failed++; $display("[TB] FAIL wrap_level: got %0d want 2", level); end
    tests_run++; if (evt_bus.evt_ch !== 2'd1) begin tests_failed++; $display("[TB] FAIL wrap_ch0: got %0d want 1", evt_bus.evt_ch); end
    tests_run++; if (evt_bus.evt_src !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_src0: got %b want 1", evt_bus.evt_src); end
    tests_run++; if (evt_bus.evt_ts !== 4'd15) begin tests_failed++; $display("[TB] FAIL wrap_ts0: got %0d want 15", evt_bus.evt_ts); end
    evt_bus.evt_ready = 1'b1;
    goto(20);
    evt_bus.evt_ready = 1'b0;
    tests_run++; if (evt_bus.evt_ts !== 4'd1) begin tests_failed++; $display("[TB] FAIL wrap_ts1: got %0d want 1", evt_bus.evt_ts); end
    tests_run++; if (evt_bus.evt_src !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_src1: got %b want 1", evt_bus.evt_src); end
    tests_run++; if (level !== 4'd1) begin tests_failed++; $display("[TB] FAIL wrap_level1: got %0d want 1", level); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    goto(2); a = 4'b0111;
    goto(3); a = '0;
    goto(6);
    tests_run++; if (level !== 4'd3) begin tests_failed++; $display("[TB] FAIL mid_level_before: got %0d want 3", level); end
    a[1] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (evt_bus.evt_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_valid: got %b want 0", evt_bus.evt_valid); end
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("[TB] FAIL mid_level: got %0d want 0", level); end
    tests_run++; if (evt_bus.evt_ts !== 4'd0) begin tests_failed++; $display("[TB] FAIL mid_ts: got %0d want 0", evt_bus.evt_ts); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_ovf: got %b want 0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    goto(2);
    tests_run++; if (evt_bus.evt_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_after_valid: got %b want 1", evt_bus.evt_valid); end
    tests_run++; if (evt_bus.evt_ch !== 2'd1) begin tests_failed++; $display("[TB] FAIL mid_after_ch: got %0d want 1", evt_bus.evt_ch); end
    tests_run++; if (evt_bus.evt_src !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_after_src: got %b want 0", evt_bus.evt_src); end
    tests_run++; if (evt_bus.evt_ts !== 4'd0) begin tests_failed++; $display("[TB] FAIL mid_after_ts: got %0d want 0", evt_bus.evt_ts); end
    goto(5);
    tests_run++; if (level !== 4'd1) begin tests_failed++; $display("[TB] FAIL mid_single_event: got %0d want 1", level); end
  endtask

  initial begin
    evt_bus.evt_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_overflow();
    test_same_cycle_regrant();
    test_ts_wrap();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/edge_event_fifo.md
Name: edge_event_fifo

Overview:
- Parametrised, multi-channel successor to the single-instance two-input (a, b) leaf block.
- Detects rising edges on NUM_CH pairs of inputs a/b and timestamps each edge.
- Arbitrates the edges round-robin into a DEPTH-entry event FIFO, which drains over a valid/ready interface.
- Sits between the replicated leaf instances and the top-level event/status logic.

Parameters:
- NUM_CH, 4: number of channels; 1..16; each channel has one a and one b input.
- DEPTH, 8: FIFO entries; power of two, >= 2.
- TS_W, 8: timestamp counter width; >= 2.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  NUM_CH  channel a inputs, synchronous to clk.
- b  input  NUM_CH  channel b inputs, synchronous to clk.
- clr  input  1  synchronous clear of pending, FIFO, pointer and overflow; does not clear the timestamp.
- evt_valid  output  1  FIFO head is valid.
- evt_ready  input  1  consumer accepts the head.
- evt_ch  output  max(1,$clog2(NUM_CH))  channel of the head event.
- evt_src  output  1  source of the head event: 0 = a, 1 = b.
- evt_ts  output  TS_W  timestamp captured at edge detection.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky lost-event flag.

Behaviour:
- Reset values: all outputs 0; edge history, pending bits, timestamp counter, FIFO pointers and RR pointer are also 0.
- Slot index: j = 2*ch + src, giving 2*NUM_CH slots.
- Timestamp: ts increments by 1 every cycle and wraps from 2^TS_W-1 to 0.
- Edge detection:
  - rise[j] = in & ~in_q in cycle k; in_q resets to 0.
  - An input already high at reset release therefore produces one event.
- Pending:
  - On rise[j], pending[j] is set at the end of cycle k and ts_slot[j] captures ts of cycle k.
  - If pending[j] is already set and not granted in cycle k, the new edge is dropped: overflow sets, ts_slot[j] keeps its old value.
  - If pending[j] is granted in cycle k, the granted entry uses the old ts_slot[j]. The new edge re-sets pending[j] with the new ts, and overflow is not set.
- Arbiter:
  - At most one grant per cycle, only when level < DEPTH.
  - Searches pending from rr_ptr upward, wrapping modulo 2*NUM_CH.
  - After granting slot j, rr_ptr becomes (j+1) mod 2*NUM_CH; with no grant, rr_ptr is unchanged.
- FIFO:
  - A grant writes {ch, src, ts_slot[j]} at the end of the grant cycle.
  - Pop occurs when evt_valid & evt_ready.
  - Push and pop in the same cycle leave level unchanged.
  - Full: no grant; pending bits hold, and new edges on held slots set overflow.
  - Push eligibility uses the registered level, so a pop in the same cycle does not enable a push when full.
- Latency: edge in cycle k, grant in k+1, evt_valid high in k+2 (FIFO empty, no contention).
- Outputs:
  - evt_ch, evt_src and evt_ts reflect the FIFO head and are 0 while empty.
  - The head is stable while evt_valid & ~evt_ready.
- clr:
  - Highest priority over grant and push.
  - Next cycle: pending = 0, FIFO empty, rr_ptr = 0, overflow = 0.
  - Edges detected during the clr cycle are discarded; in_q still updates.
- Reset mid-operation: asynchronous; all state returns to reset values immediately, with no partial event emitted.
- Overflow clears only on clr or reset.

Test Plan:
- Reset, then pulse a[2] high at cycle 5 → evt_valid at cycle 7 with evt_ch=2, evt_src=0, evt_ts=5, level=1; pop with evt_ready=1 → level=0.
- a[0], b[0] and a[3] rise together at cycle 10, rr_ptr=0, evt_ready=0 → FIFO order slots 0, 1, 6 with ts 10, 10, 10; rr_ptr=7.
- Hold evt_ready=0 and toggle distinct slots until level=8 → no further grants, pending held; an edge on a held slot sets overflow=1; clr → level=0, overflow=0.
- A second rise on slot 4 in the same cycle slot 4 is granted → two events for slot 4 with different ts, overflow stays 0.
- Timestamp wrap (TS_W=4): edges at cycles 15 and 17 → evt_ts 15 then 1.
- Assert rst_n=0 mid-stream with level=3 → all outputs 0 asynchronously; after release, a[1] already high → one event ch=1.
